// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI read scheduler.
//   state_t    : scheduler FSM states
//   ID_*       : AXI IDs assigned to each requester
//   BURST_INCR : AR burst type driven on the outer bus
//   SIZE_WORD  : fixed transfer size of the I-cache and D-cache ports
package axi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;
  localparam logic [3:0] ID_U = 4'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/ar_pick.sv
// Combinational winner selection for the read scheduler.
// Fixed priority d > u > i, overridden in favour of i once it has lost
// STARVE_LIMIT consecutive arbitrations.
//   i_valid/d_valid/u_valid : requester arvalid inputs
//   starve_cnt              : consecutive lost arbitrations of the i-port
//   win_valid               : at least one requester is asking
//   win_id                  : ID of the winning requester
module ar_pick
  import axi_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             i_valid,
  input  logic             d_valid,
  input  logic             u_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             win_valid,
  output logic [3:0]       win_id
);

  always_comb begin
    win_valid = i_valid | d_valid | u_valid;
    win_id    = ID_I;
    if (i_valid && (starve_cnt == CNT_W'(STARVE_LIMIT))) win_id = ID_I;
    else if (d_valid)                                    win_id = ID_D;
    else if (u_valid)                                    win_id = ID_U;
  end

endmodule

// File: rtl/axi_read_sched.sv
// Schedules read bursts from I-cache, D-cache and uncached requesters onto
// one outer AXI read port, one burst outstanding at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   {i,d,u}_ar*              : per-requester AR channel (size fixed for i/d)
//   {i,d,u}_r*               : per-requester R channel, routed to the grantee
//   ar*, r*                  : outer AXI read channels
//   rd_err                   : one-cycle pulse after a faulty burst completes
//
// state | meaning
// IDLE  | waiting for any requester; picks and latches a winner
// ADDR  | driving outer AR with latched fields until arready
// DATA  | forwarding beats to the grantee until the rlast handshake
module axi_read_sched
  import axi_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [31:0] d_araddr,
  input  logic [31:0] u_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [7:0]  d_arlen,
  input  logic [7:0]  u_arlen,
  input  logic [2:0]  u_arsize,
  input  logic        i_arvalid,
  input  logic        d_arvalid,
  input  logic        u_arvalid,
  output logic        i_arready,
  output logic        d_arready,
  output logic        u_arready,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic [31:0] u_rdata,
  output logic        i_rlast,
  output logic        d_rlast,
  output logic        u_rlast,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic        u_rvalid,
  input  logic        i_rready,
  input  logic        d_rready,
  input  logic        u_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  // +2 keeps the width non-zero for STARVE_LIMIT = 0.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  state_t           state;
  logic [31:0]      lat_addr;
  logic [7:0]       lat_len;
  logic [2:0]       lat_size;
  logic [3:0]       lat_id;
  logic [CNT_W-1:0] starve_cnt;
  logic [7:0]       beat_cnt;
  logic             err_flag;
  logic             rd_err_q;

  logic             win_valid;
  logic [3:0]       win_id;

  ar_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .i_valid   (i_arvalid),
    .d_valid   (d_arvalid),
    .u_valid   (u_arvalid),
    .starve_cnt(starve_cnt),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  logic in_addr, in_data, sel_i, sel_d, sel_u, r_hs, beat_bad, burst_bad;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign sel_i   = (lat_id == ID_I);
  assign sel_d   = (lat_id == ID_D);
  assign sel_u   = (lat_id == ID_U);

  assign arvalid = in_addr;
  assign arid    = lat_id;
  assign araddr  = lat_addr;
  assign arlen   = lat_len;
  assign arsize  = lat_size;
  assign arburst = BURST_INCR;

  assign i_arready = in_addr && arready && sel_i;
  assign d_arready = in_addr && arready && sel_d;
  assign u_arready = in_addr && arready && sel_u;

  // Outside DATA rready stays low so stray beats are never accepted.
  assign rready = in_data && ((sel_i && i_rready) || (sel_d && d_rready) ||
                              (sel_u && u_rready));

  assign i_rvalid = in_data && sel_i && rvalid;
  assign d_rvalid = in_data && sel_d && rvalid;
  assign u_rvalid = in_data && sel_u && rvalid;
  assign i_rlast  = in_data && sel_i && rlast;
  assign d_rlast  = in_data && sel_d && rlast;
  assign u_rlast  = in_data && sel_u && rlast;
  assign i_rdata  = (in_data && sel_i) ? rdata : '0;
  assign d_rdata  = (in_data && sel_d) ? rdata : '0;
  assign u_rdata  = (in_data && sel_u) ? rdata : '0;

  assign r_hs      = rvalid && rready;
  assign beat_bad  = (rresp != 2'b00) || (rid != lat_id);
  // beat_cnt holds the beats before this one, so a well-formed burst
  // reaches rlast with beat_cnt == arlen.
  assign burst_bad = err_flag || beat_bad || (beat_cnt != lat_len);

  assign rd_err = rd_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_len    <= '0;
      lat_size   <= '0;
      lat_id     <= '0;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      err_flag   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            lat_id <= win_id;
            case (win_id)
              ID_D: begin
                lat_addr <= d_araddr;
                lat_len  <= d_arlen;
                lat_size <= SIZE_WORD;
              end
              ID_U: begin
                lat_addr <= u_araddr;
                lat_len  <= u_arlen;
                lat_size <= u_arsize;
              end
              default: begin
                lat_addr <= i_araddr;
                lat_len  <= i_arlen;
                lat_size <= SIZE_WORD;
              end
            endcase
            if (win_id == ID_I)
              starve_cnt <= '0;
            else if (i_arvalid && (starve_cnt != CNT_W'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            beat_cnt <= '0;
            err_flag <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            err_flag <= err_flag | beat_bad;
            if (rlast) begin
              rd_err_q <= burst_bad;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_sched.sv
module tb_axi_read_sched;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        p_v   [3];
  logic [31:0] p_addr[3];
  logic [7:0]  p_len [3];
  logic [2:0]  p_size[3];
  logic        rr    [3];

  logic [31:0] i_rdata, d_rdata, u_rdata;
  logic        i_arready, d_arready, u_arready;
  logic        i_rlast, d_rlast, u_rlast, i_rvalid, d_rvalid, u_rvalid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready, rready, rd_err;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;

  axi_read_sched #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(p_addr[0]), .d_araddr(p_addr[1]), .u_araddr(p_addr[2]),
    .i_arlen(p_len[0]), .d_arlen(p_len[1]), .u_arlen(p_len[2]),
    .u_arsize(p_size[2]),
    .i_arvalid(p_v[0]), .d_arvalid(p_v[1]), .u_arvalid(p_v[2]),
    .i_arready(i_arready), .d_arready(d_arready), .u_arready(u_arready),
    .i_rdata(i_rdata), .d_rdata(d_rdata), .u_rdata(u_rdata),
    .i_rlast(i_rlast), .d_rlast(d_rlast), .u_rlast(u_rlast),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .u_rvalid(u_rvalid),
    .i_rready(rr[0]), .d_rready(rr[1]), .u_rready(rr[2]),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rd_err(rd_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int starve = 0;
  logic [3:0] obs_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] xarr();
    return {29'd0, u_arready, d_arready, i_arready};
  endfunction

  function automatic logic [31:0] xrv();
    return {29'd0, u_rvalid, d_rvalid, i_rvalid};
  endfunction

  function automatic logic [31:0] rdata_of(input int w);
    return (w == 0) ? i_rdata : (w == 1) ? d_rdata : u_rdata;
  endfunction

  function automatic logic rlast_of(input int w);
    return (w == 0) ? i_rlast : (w == 1) ? d_rlast : u_rlast;
  endfunction

  // Reference arbitration: d beats u beats i, unless i has lost LIM times in a row.
  function automatic int model_pick();
    int w;
    if (p_v[0] && starve == LIM) w = 0;
    else if (p_v[1])             w = 1;
    else if (p_v[2])             w = 2;
    else                         w = 0;
    if (w == 0) starve = 0;
    else if (p_v[0] && starve < LIM) starve++;
    return w;
  endfunction

  task automatic req(input int p, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    p_v[p] = 1'b1;
    p_addr[p] = a;
    p_len[p] = l;
    p_size[p] = (p == 2) ? s : 3'b010;
  endtask

  task automatic req_rand(input int p);
    req(p, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)));
  endtask

  // Entered at a negedge with the DUT in IDLE and at least one request pending.
  // nb <= 0 means a well-formed burst of arlen+1 beats.
  task automatic burst(input int nb_in, input int bad_beat, input bit bad_rid,
                       input bit refill, input int rst_at);
    int w, nb, tries;
    bit exp_err, hs;
    logic [31:0] ea, d;
    logic [7:0] el;
    logic [2:0] es;
    logic [3:0] rid_v;
    w = model_pick();
    ea = p_addr[w]; el = p_len[w]; es = p_size[w];
    nb = (nb_in <= 0) ? int'(el) + 1 : nb_in;
    rid_v = bad_rid ? 4'(w + 5) : 4'(w);
    exp_err = bad_rid || (bad_beat >= 0 && bad_beat < nb) || (nb != int'(el) + 1);
    @(negedge clk);
    obs_id = arid;
    check("arvalid", 32'(arvalid), 32'd1);
    check("arid", 32'(arid), 32'(w));
    check("araddr", araddr, ea);
    check("arlen", 32'(arlen), 32'(el));
    check("arsize", 32'(arsize), 32'(es));
    check("arburst", 32'(arburst), 32'd1);
    check("rd_err_idle", 32'(rd_err), 32'd0);
    check("xarready_wait", xarr(), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("ar_hold_valid", 32'(arvalid), 32'd1);
      check("ar_hold_addr", araddr, ea);
    end
    arready = 1'b1;
    #1;
    check("xarready", xarr(), 32'(1 << w));
    @(negedge clk);
    arready = 1'b0;
    p_v[w] = 1'b0;
    if (refill) req_rand(w);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      d = $urandom;
      rvalid = 1'b1; rdata = d; rlast = (b == nb - 1); rid = rid_v;
      rresp = (b == bad_beat) ? 2'b10 : 2'b00;
      if (b == rst_at) begin
        rr[w] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_xarready", xarr(), 32'd0);
        check("rst_xrvalid", xrv(), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        rst = 1'b0;
        starve = 0;
        repeat (3) begin
          @(negedge clk);
          check("stray_rready", 32'(rready), 32'd0);
          check("stray_xrvalid", xrv(), 32'd0);
          check("stray_arvalid", 32'(arvalid), 32'd0);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rr[w] = 1'b0;
        return;
      end
      tries = 0;
      hs = 1'b0;
      while (!hs) begin
        rr[w] = (tries >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        check("rvalid_route", xrv(), 32'(1 << w));
        check("rdata_route", rdata_of(w), d);
        check("rlast_route", 32'(rlast_of(w)), 32'(rlast));
        check("rready", 32'(rready), 32'(rr[w]));
        hs = rr[w];
        @(negedge clk);
        tries++;
      end
      rvalid = 1'b0; rr[w] = 1'b0;
    end
    rlast = 1'b0; rresp = 2'b00;
    check("rd_err", 32'(rd_err), 32'(exp_err));
    check("back_idle", 32'(arvalid), 32'd0);
    check("idle_rready", 32'(rready), 32'd0);
  endtask

  task automatic drain();
    while (p_v[0] || p_v[1] || p_v[2]) burst(0, -1, 1'b0, 1'b0, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f;
    for (int p = 0; p < 3; p++) begin
      p_v[p] = 1'b0; p_addr[p] = '0; p_len[p] = '0; p_size[p] = 3'b010; rr[p] = 1'b0;
    end
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_arvalid", 32'(arvalid), 32'd0);
    check("reset_rready", 32'(rready), 32'd0);
    check("reset_xarready", xarr(), 32'd0);
    check("reset_xrvalid", xrv(), 32'd0);
    check("reset_rd_err", 32'(rd_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single I-cache line fill
    req(0, 32'hBFC0_0000, 8'd7, 3'b010);
    burst(0, -1, 1'b0, 1'b0, -1);
    check("icache_id", 32'(obs_id), 32'd0);

    // d and i together: d first, then i
    req(1, 32'h8000_1000, 8'd3, 3'b010);
    req(0, 32'hBFC0_0020, 8'd3, 3'b010);
    burst(0, -1, 1'b0, 1'b0, -1);
    check("d_first", 32'(obs_id), 32'd1);
    burst(0, -1, 1'b0, 1'b0, -1);
    check("i_second", 32'(obs_id), 32'd0);

    // continuous d/u traffic: i must win the fifth arbitration
    req(0, 32'hBFC0_0040, 8'd1, 3'b010);
    req(1, 32'h8000_2000, 8'd1, 3'b010);
    req(2, 32'h1FAF_0100, 8'd0, 3'b010);
    for (int k = 0; k < 4; k++) begin
      burst(0, -1, 1'b0, 1'b1, -1);
      check("starve_d_win", 32'(obs_id), 32'd1);
    end
    burst(0, -1, 1'b0, 1'b0, -1);
    check("starve_i_win", 32'(obs_id), 32'd0);
    drain();

    // early rlast
    req(0, 32'hBFC0_0080, 8'd7, 3'b010);
    burst(4, -1, 1'b0, 1'b0, -1);

    // uncached byte read with SLVERR
    req(2, 32'h1FAF_0000, 8'd0, 3'b000);
    burst(0, 0, 1'b0, 1'b0, -1);
    check("uncached_id", 32'(obs_id), 32'd2);

    // reset in the middle of a burst
    req(0, 32'hBFC0_00C0, 8'd7, 3'b010);
    burst(0, -1, 1'b0, 1'b0, 2);

    // randomized traffic with occasional faults
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 3; p++)
        if (!p_v[p] && $urandom_range(0, 2) != 0) req_rand(p);
      if (!(p_v[0] || p_v[1] || p_v[2])) req_rand($urandom_range(0, 2));
      f = $urandom_range(0, 9);
      burst((f == 0) ? $urandom_range(1, 9) : 0,
            (f == 1) ? $urandom_range(0, 3) : -1,
            f == 2, 1'($urandom_range(0, 1)), -1);
    end
    drain();
    @(negedge clk);
    check("final_rd_err", 32'(rd_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_read_sched.md
AXI_READ_SCHED -- requirements
Module: axi_read_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost arbitrations after which the i-port wins outright.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_araddr/d_araddr/u_araddr  input  32  read address per requester (i = I-cache, d = D-cache, u = uncached).
REQ-005 SHALL have ports i_arlen/d_arlen/u_arlen  input  8  burst length minus one.
REQ-006 SHALL have port u_arsize  input  3  uncached transfer size; the i-port and d-port are fixed at 3'b010.
REQ-007 SHALL have ports i_arvalid/d_arvalid/u_arvalid  input  1, and i_arready/d_arready/u_arready  output  1  per-requester AR handshake.
REQ-008 SHALL have ports i_rdata/d_rdata/u_rdata  output  32, i_rlast/d_rlast/u_rlast  output  1, i_rvalid/d_rvalid/u_rvalid  output  1, and i_rready/d_rready/u_rready  input  1  per-requester R channel.
REQ-009 SHALL have ports arid  output  4, araddr  output  32, arlen  output  8, arsize  output  3, arburst  output  2, arvalid  output  1, and arready  input  1  outer AXI AR channel.
REQ-010 SHALL have ports rid  input  4, rdata  input  32, rresp  input  2, rlast  input  1, rvalid  input  1, and rready  output  1  outer AXI R channel.
REQ-011 SHALL have port rd_err  output  1  one-cycle pulse on a faulty burst completion.

Function
REQ-012 SHALL implement a FSM with states IDLE, ADDR and DATA; at most one burst is outstanding.
REQ-013 IDLE: if any arvalid is high, SHALL pick a winner, latch its addr, len, size and ID (i=0, d=1, u=2), and go to ADDR next cycle; otherwise SHALL stay in IDLE.
REQ-014 Priority SHALL be d > u > i, except that i wins whenever starve_cnt == STARVE_LIMIT and i_arvalid is high.
REQ-015 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each IDLE pick where i_arvalid is high and i loses, and SHALL clear when i is granted.
REQ-016 ADDR: arvalid SHALL be 1 with latched fields and arburst = 2'b01 (INCR); fields SHALL be stable until arready.
REQ-017 ADDR: on arready, the winner's Xarready SHALL pulse high combinationally in that cycle and the FSM SHALL go to DATA; the other Xarready SHALL be 0.
REQ-018 A request asserted in IDLE cycle N SHALL produce outer arvalid in cycle N+1.
REQ-019 DATA: rdata/rvalid/rlast SHALL route combinationally to the granted port only; rready = granted Xrready; the other ports' rvalid SHALL be 0.
REQ-020 DATA: an 8-bit beat counter SHALL increment on each rvalid&rready handshake; the FSM SHALL return to IDLE the cycle after a handshake with rlast=1.
REQ-021 rd_err SHALL pulse in the cycle after the rlast handshake if rresp != 2'b00 on any beat of the burst, the beat count at rlast != latched arlen, or rid != latched ID.
REQ-022 Beats arriving while rvalid is high and not in DATA SHALL be ignored with rready = 0.
REQ-023 Requesters SHALL hold arvalid and fields until their arready; a requester dropping arvalid before being granted at IDLE is not considered.

Reset
REQ-024 On rst: state = IDLE, starve_cnt = 0, beat counter = 0, latched fields = 0, error flag = 0; arvalid, rready, all Xarready, all Xrvalid and rd_err SHALL be 0 in the following cycle.
REQ-025 Reset during ADDR or DATA SHALL abandon the burst without a downstream pulse; remaining beats SHALL be ignored per REQ-022.

Structure
REQ-026 Package axi_sched_pkg SHALL hold the state enum, ID constants (ID_I=0, ID_D=1, ID_U=2), BURST_INCR=2'b01, and SIZE_WORD=3'b010.
REQ-027 The combinational winner selection (priority plus starvation override) SHALL be the sub-module ar_pick; all other logic is in axi_read_sched.

Verification
REQ-028 Only i_arvalid, addr 0xBFC00000, len 7 -> arvalid at N+1, arid 0, arlen 7, arburst 01; 8 beats forwarded to i-port; IDLE after last; rd_err 0.
REQ-029 d and i assert simultaneously -> d granted first (arid 1); i granted on the next IDLE.
REQ-030 d and u continuously request with i pending, STARVE_LIMIT=4 -> i granted on the 5th arbitration; starve_cnt then 0.
REQ-031 Outer slave returns rlast on beat 3 for arlen 7 -> rd_err pulses once, FSM returns to IDLE.
REQ-032 u request, arsize 3'b000, addr 0x1FAF0000, len 0, beat with rresp 2'b10 -> arsize 000 on bus, u_rvalid 1 for one beat, rd_err pulse.
REQ-033 rst asserted mid-DATA (beat 2 of 8) -> next cycle all valids/readys 0, state IDLE; stray rvalid beats not accepted.
